// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV32I core: FSM states,
// opcode constants, datapath mux-select encodings and trap cause codes.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BRANCH,
      S_JALR_ADR,
      S_JAL,
      S_LUI,
      S_AUIPC,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;
   localparam logic [1:0] SRC_A_ZERO  = 2'b11;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;

   localparam logic [1:0] PC_ALURESULT = 2'b00;
   localparam logic [1:0] PC_ALUOUT    = 2'b01;
   localparam logic [1:0] PC_TRAP      = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been outstanding and flags when the
// wait budget is used up. WAIT_LIMIT of 0 disables expiry.
module mem_wait_timer #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   assign expired = (WAIT_LIMIT != 0) && (cnt_q == CNT_WIDTH'(WAIT_LIMIT));

   // Saturate at the limit so a stalled request cannot wrap back below it.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, raising traps on bad opcodes and stalls.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH = 7,
   parameter int WAIT_LIMIT   = 16,
   parameter int CNT_WIDTH    = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    mem_ready,
   output logic                    pc_write,
   output logic                    branch,
   output logic                    ir_write,
   output logic                    adr_src,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic                    reg_write,
   output logic [1:0]              alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              result_src,
   output logic [1:0]              pc_src,
   output logic                    trap_valid,
   output logic [1:0]              trap_cause,
   output logic                    instr_retired
);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] cause_q;
   logic [1:0] cause_d;
   logic       timer_clear;
   logic       timer_expired;

   mem_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (mem_req),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RESET;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cause_d       = cause_q;
      pc_write      = 1'b0;
      branch        = 1'b0;
      ir_write      = 1'b0;
      adr_src       = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      alu_op        = ALU_ADD;
      result_src    = RES_ALUOUT;
      pc_src        = PC_ALURESULT;
      trap_valid    = 1'b0;
      trap_cause    = CAUSE_NONE;
      instr_retired = 1'b0;

      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            // mem_ready has priority over an expiring wait budget.
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timer_expired) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_TRAP;
            end
         end
         S_DECODE: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR_ADR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default: begin
                  cause_d = CAUSE_ILLEGAL;
                  state_d = S_TRAP;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timer_expired) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_TRAP;
            end
         end
         S_MEMWB: begin
            reg_write     = 1'b1;
            result_src    = RES_RDATA;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end else if (timer_expired) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_TRAP;
            end
         end
         S_EXEC_R: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write     = 1'b1;
            result_src    = RES_ALUOUT;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = SRC_A_RS1;
            alu_src_b     = SRC_B_RS2;
            alu_op        = ALU_BRANCH;
            branch        = 1'b1;
            result_src    = RES_ALUOUT;
            pc_src        = PC_ALUOUT;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_JALR_ADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = S_JAL;
         end
         S_JAL: begin
            // Jump to the target held in ALUOut while computing the link value.
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_FOUR;
            pc_write  = 1'b1;
            pc_src    = PC_ALUOUT;
            state_d   = S_ALUWB;
         end
         S_TRAP: begin
            trap_valid = 1'b1;
            trap_cause = cause_q;
            pc_write   = 1'b1;
            pc_src     = PC_TRAP;
            state_d    = S_FETCH;
         end
         default: state_d = S_RESET;
      endcase

      // Restart the wait budget on every new access and on each completion.
      timer_clear = (mem_req && mem_ready) ||
                    (is_mem_state(state_d) && (state_d != state_q));
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle plan derived from the
// instruction-class rules is compared against every DUT output each cycle.
module tb_multicycle_ctrl;

   localparam int LIMIT = 4;

   typedef struct packed {
      logic       pc_write, branch, ir_write, adr_src, mem_req, mem_we, reg_write;
      logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, pc_src;
      logic       trap_valid;
      logic [1:0] trap_cause;
      logic       instr_retired;
   } outs_t;

   typedef struct {
      outs_t      exp;
      logic       ready;
      bit         rand_op;
      logic [6:0] op;
   } step_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       pc_write, branch, ir_write, adr_src, mem_req, mem_we, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, pc_src, trap_cause;
   logic       trap_valid, instr_retired;
   outs_t      obs;

   int    errors = 0;
   int    checks = 0;
   step_t plan[$];

   multicycle_ctrl #(
      .OPCODE_WIDTH (7),
      .WAIT_LIMIT   (LIMIT),
      .CNT_WIDTH    (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .branch        (branch),
      .ir_write      (ir_write),
      .adr_src       (adr_src),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .result_src    (result_src),
      .pc_src        (pc_src),
      .trap_valid    (trap_valid),
      .trap_cause    (trap_cause),
      .instr_retired (instr_retired)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, branch, ir_write, adr_src, mem_req, mem_we, reg_write,
                 alu_src_a, alu_src_b, alu_op, result_src, pc_src,
                 trap_valid, trap_cause, instr_retired};

   task automatic check_outs(string tag, outs_t o, outs_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check_int(string tag, int o, int e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic push(outs_t e, logic rdy, bit rnd, logic [6:0] op);
      step_t s;
      s.exp = e; s.ready = rdy; s.rand_op = rnd; s.op = op;
      plan.push_back(s);
   endtask

   // Non-memory cycle: mem_ready is driven randomly and must have no effect.
   task automatic push_plain(outs_t e, logic [6:0] op);
      push(e, 1'($urandom), 1'b0, op);
   endtask

   task automatic push_trap(logic [1:0] cause, logic [6:0] op);
      outs_t e = '0;
      e.trap_valid = 1'b1; e.trap_cause = cause; e.pc_write = 1'b1; e.pc_src = 2'b10;
      push_plain(e, op);
   endtask

   task automatic push_aluwb(logic [6:0] op);
      outs_t e = '0;
      e.reg_write = 1'b1; e.instr_retired = 1'b1;
      push_plain(e, op);
   endtask

   // A memory access: waits idle request cycles, then either completion or,
   // with to set, LIMIT+1 unanswered request cycles followed by a timeout trap.
   task automatic push_access(outs_t wait_e, outs_t done_e, int waits, bit to,
                              bit rnd, logic [6:0] op, output bit trapped);
      trapped = to;
      if (to) begin
         for (int i = 0; i <= LIMIT; i++) push(wait_e, 1'b0, rnd, op);
         push_trap(2'b10, op);
      end else begin
         for (int i = 0; i < waits; i++) push(wait_e, 1'b0, rnd, op);
         push(done_e, 1'b1, rnd, op);
      end
   endtask

   task automatic build(logic [6:0] op, int fw, bit fto, int dw, bit dto);
      outs_t e, r;
      bit    trapped;
      e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b10;
      r = e;  r.ir_write = 1'b1; r.pc_write = 1'b1;
      push_access(e, r, fw, fto, 1'b1, op, trapped);
      if (trapped) return;
      e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
      push_plain(e, op);
      case (op)
         7'b0000011, 7'b0100011: begin
            e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
            push_plain(e, op);
            e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1;
            if (op == 7'b0100011) begin
               e.mem_we = 1'b1;
               r = e; r.instr_retired = 1'b1;
               push_access(e, r, dw, dto, 1'b0, op, trapped);
            end else begin
               push_access(e, e, dw, dto, 1'b0, op, trapped);
               if (!trapped) begin
                  r = '0; r.reg_write = 1'b1; r.result_src = 2'b01; r.instr_retired = 1'b1;
                  push_plain(r, op);
               end
            end
         end
         7'b0110011, 7'b0010011: begin
            e = '0; e.alu_src_a = 2'b10; e.alu_op = 2'b10;
            e.alu_src_b = (op == 7'b0010011) ? 2'b01 : 2'b00;
            push_plain(e, op);
            push_aluwb(op);
         end
         7'b0110111, 7'b0010111: begin
            e = '0; e.alu_src_b = 2'b01;
            e.alu_src_a = (op == 7'b0110111) ? 2'b11 : 2'b01;
            push_plain(e, op);
            push_aluwb(op);
         end
         7'b1100011: begin
            e = '0; e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.branch = 1'b1;
            e.pc_src = 2'b01; e.instr_retired = 1'b1;
            push_plain(e, op);
         end
         7'b1101111, 7'b1100111: begin
            if (op == 7'b1100111) begin
               e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
               push_plain(e, op);
            end
            e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; e.pc_src = 2'b01;
            push_plain(e, op);
            push_aluwb(op);
         end
         default: push_trap(2'b01, op);
      endcase
   endtask

   // Plays up to max_steps planned cycles; retire_at is the cycle (1-based)
   // in which the DUT first pulsed instr_retired, 0 if never.
   task automatic run_plan(string tag, int max_steps, output int retire_at);
      step_t s;
      int    n;
      n = 0;
      retire_at = 0;
      while (plan.size() > 0 && n < max_steps) begin
         s = plan.pop_front();
         @(negedge clk);
         mem_ready = s.ready;
         opcode    = s.rand_op ? 7'($urandom) : s.op;
         #1;
         n++;
         check_outs($sformatf("%s.cyc%0d", tag, n), obs, s.exp);
         if (obs.instr_retired && retire_at == 0) retire_at = n;
      end
   endtask

   task automatic run_instr(string tag, logic [6:0] op, int fw, bit fto,
                            int dw, bit dto, output int retire_at);
      build(op, fw, fto, dw, dto);
      run_plan(tag, 1000, retire_at);
      $display("instr %-8s op=%b fetch_wait=%0d fto=%0d data_wait=%0d dto=%0d retired_at=%0d",
               tag, op, fw, fto, dw, dto, retire_at);
   endtask

   logic [6:0] legal_ops [10];
   int         ret;

   initial begin
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011};

      repeat (2) @(negedge clk);
      #1;
      check_outs("rst_high", obs, '0);
      rst = 1'b0;
      #1;
      check_outs("reset_state", obs, '0);

      run_instr("add_w3", 7'b0110011, 3, 0, 0, 0, ret);
      check_int("add_w3_lat", ret, 7);
      run_instr("add", 7'b0110011, 0, 0, 0, 0, ret);
      check_int("add_lat", ret, 4);
      run_instr("lw_w2", 7'b0000011, 0, 0, 2, 0, ret);
      check_int("lw_w2_lat", ret, 7);
      run_instr("sw", 7'b0100011, 0, 0, 1, 0, ret);
      check_int("sw_lat", ret, 5);
      run_instr("illegal", 7'b0000000, 0, 0, 0, 0, ret);
      check_int("illegal_noret", ret, 0);
      run_instr("f_tmo", 7'b0110011, 0, 1, 0, 0, ret);
      check_int("f_tmo_noret", ret, 0);
      run_instr("f_edge", 7'b0110011, LIMIT, 0, 0, 0, ret);
      check_int("f_edge_lat", ret, 4 + LIMIT);
      run_instr("lw_tmo", 7'b0000011, 0, 0, 0, 1, ret);
      run_instr("sw_edge", 7'b0100011, 0, 0, LIMIT, 0, ret);
      check_int("sw_edge_lat", ret, 4 + LIMIT);
      run_instr("sw_tmo", 7'b0100011, 1, 0, 0, 1, ret);
      run_instr("jalr", 7'b1100111, 0, 0, 0, 0, ret);
      check_int("jalr_lat", ret, 5);
      run_instr("jal", 7'b1101111, 0, 0, 0, 0, ret);
      check_int("jal_lat", ret, 4);
      run_instr("beq", 7'b1100011, 0, 0, 0, 0, ret);
      check_int("beq_lat", ret, 3);

      for (int i = 0; i < 80; i++) begin
         logic [6:0] op;
         int         fw, dw;
         bit         fto, dto;
         op  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)];
         fw  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, LIMIT) : 0;
         dw  = $urandom_range(0, LIMIT);
         fto = ($urandom_range(0, 11) == 0);
         dto = ($urandom_range(0, 7) == 0);
         run_instr($sformatf("rnd%0d", i), op, fw, fto, dw, dto, ret);
      end

      // Reset asserted mid-store: request must vanish without waiting for an edge.
      build(7'b0100011, 0, 0, 3, 0);
      run_plan("sw_rst", 4, ret);
      plan.delete();
      check_int("sw_rst_req_before", int'(mem_req), 1);
      rst = 1'b1;
      #1;
      check_int("sw_rst_req_drop", int'(mem_req), 0);
      check_outs("sw_rst_outs", obs, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outs("reset_state2", obs, '0);
      run_instr("add_post", 7'b0110011, 0, 0, 0, 0, ret);
      check_int("add_post_lat", ret, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
